// File: rtl/prog_ctrl_pkg.sv
// rtl/prog_ctrl_pkg.sv - shared state encoding and address-field constants for prog_mode_ctrl
package prog_ctrl_pkg;

  localparam int UPG_ADR_W       = 15;
  localparam int ROM_RAM_SEL_BIT = 14;

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_RUN     = 2'd1,
    ST_PROG    = 2'd2
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, stability counter and single press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ARM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  // Counter parks at CNT_MAX while held, so the arm value is crossed once per press.
  always_comb begin
    cnt_d = '0;
    if (sync2_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
  end

  assign press_o = sync2_q && (cnt_q == CNT_ARM);

endmodule

// File: rtl/prog_mode_ctrl.sv
// rtl/prog_mode_ctrl.sv - RUN/PROG sequencer, write steering and word counters
// Optional macro PROG_TIMEOUT_EN: abort a stalled PROG session after TIMEOUT_CYCLES idle cycles.
module prog_mode_ctrl
  import prog_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int RELEASE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES  = 23000000,
  parameter int CNT_W           = 14
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_pg,
  input  logic                 upg_wen_i,
  input  logic [UPG_ADR_W-1:0] upg_adr_i,
  input  logic                 upg_done_i,
  output logic                 upg_rst_o,
  output logic                 cpu_rst_o,
  output logic                 rom_wen_o,
  output logic                 ram_wen_o,
  output logic [CNT_W-1:0]     rom_words_o,
  output logic [CNT_W-1:0]     ram_words_o,
  output logic [1:0]           mode_o,
  output logic                 prog_err_o
);

  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [RW-1:0]    rel_cnt_q, rel_cnt_d;
  logic [CNT_W-1:0] rom_cnt_q, rom_cnt_d;
  logic [CNT_W-1:0] ram_cnt_q, ram_cnt_d;
  logic             press;
  logic             prog_entry;
  logic             in_prog;
  logic             timeout_hit;
  logic             unused_adr_bits;

  assign unused_adr_bits = ^upg_adr_i[ROM_RAM_SEL_BIT-1:0];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i  (clock),
    .rst_ni (reset),
    .btn_i  (start_pg),
    .press_o(press)
  );

  assign in_prog    = (state_q == ST_PROG);
  assign prog_entry = (state_q == ST_RUN) && press;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RELEASE;
      rel_cnt_q <= '0;
      rom_cnt_q <= '0;
      ram_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rel_cnt_q <= rel_cnt_d;
      rom_cnt_q <= rom_cnt_d;
      ram_cnt_q <= ram_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rel_cnt_d = '0;
    rom_cnt_d = rom_cnt_q;
    ram_cnt_d = ram_cnt_q;
    upg_rst_o = 1'b1;
    cpu_rst_o = 1'b1;
    rom_wen_o = 1'b0;
    ram_wen_o = 1'b0;
    case (state_q)
      ST_RELEASE: begin
        if (rel_cnt_q == REL_LAST) state_d = ST_RUN;
        else rel_cnt_d = rel_cnt_q + RW'(1);
      end
      ST_RUN: begin
        cpu_rst_o = 1'b0;
        if (prog_entry) begin
          state_d   = ST_PROG;
          rom_cnt_d = '0;
          ram_cnt_d = '0;
        end
      end
      ST_PROG: begin
        upg_rst_o = 1'b0;
        rom_wen_o = upg_wen_i & ~upg_adr_i[ROM_RAM_SEL_BIT];
        ram_wen_o = upg_wen_i &  upg_adr_i[ROM_RAM_SEL_BIT];
        if (rom_wen_o && (rom_cnt_q != '1)) rom_cnt_d = rom_cnt_q + CNT_W'(1);
        if (ram_wen_o && (ram_cnt_q != '1)) ram_cnt_d = ram_cnt_q + CNT_W'(1);
        // A write in the done cycle is still forwarded and counted above.
        if (upg_done_i || timeout_hit) state_d = ST_RELEASE;
      end
      default: state_d = ST_RELEASE;
    endcase
  end

`ifdef PROG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_q;
  logic          armed_q;
  logic          err_q;

  // Done takes priority: a session that completes on the timeout cycle is not an error.
  assign timeout_hit = armed_q && !upg_wen_i && !upg_done_i && (idle_q == TO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_q  <= '0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (prog_entry) err_q <= 1'b0;
      else if (in_prog && timeout_hit) err_q <= 1'b1;

      if (!in_prog) begin
        idle_q  <= '0;
        armed_q <= 1'b0;
      end else if (upg_wen_i) begin
        idle_q  <= '0;
        armed_q <= 1'b1;
      end else if (armed_q) begin
        idle_q  <= idle_q + TW'(1);
      end
    end
  end

  assign prog_err_o = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign prog_err_o  = 1'b0;
`endif

  assign rom_words_o = rom_cnt_q;
  assign ram_words_o = ram_cnt_q;
  assign mode_o      = state_q;

endmodule

// File: tb/tb_prog_mode_ctrl.sv
// tb/tb_prog_mode_ctrl.sv - directed bench with per-cycle behavioural model for prog_mode_ctrl
module tb_prog_mode_ctrl;

  localparam int DEB = 4;
  localparam int REL = 3;
  localparam int TO  = 10;
  localparam int CW  = 14;
  localparam int SAT = (1 << CW) - 1;
`ifdef PROG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start_pg = 1'b0;
  logic          upg_wen_i = 1'b0;
  logic [14:0]   upg_adr_i = '0;
  logic          upg_done_i = 1'b0;
  logic          upg_rst_o, cpu_rst_o, rom_wen_o, ram_wen_o, prog_err_o;
  logic [CW-1:0] rom_words_o, ram_words_o;
  logic [1:0]    mode_o;

  prog_mode_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RELEASE_CYCLES (REL),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start_pg   (start_pg),
    .upg_wen_i  (upg_wen_i),
    .upg_adr_i  (upg_adr_i),
    .upg_done_i (upg_done_i),
    .upg_rst_o  (upg_rst_o),
    .cpu_rst_o  (cpu_rst_o),
    .rom_wen_o  (rom_wen_o),
    .ram_wen_o  (ram_wen_o),
    .rom_words_o(rom_words_o),
    .ram_words_o(ram_words_o),
    .mode_o     (mode_o),
    .prog_err_o (prog_err_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: mode 0/1/2, cycles spent in release, word counts, error flag,
  // idle cycles since last write (-1 = none yet), run length of raw button highs.
  int m_mode, m_rel, m_rom, m_ram, m_err, m_since;
  int run_now, run_prev, nr;
  bit m_press;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_rel = 0; m_rom = 0; m_ram = 0; m_err = 0; m_since = -1;
      run_now = 0; run_prev = 0;
    end else begin
      // Press lands two cycles after the DEB-th consecutive high sample.
      m_press  = (run_prev == DEB);
      nr       = start_pg ? ((run_now > DEB) ? run_now : run_now + 1) : 0;
      run_prev = run_now;
      run_now  = nr;
      case (m_mode)
        0: begin
          m_rel++;
          if (m_rel == REL) begin m_mode = 1; m_rel = 0; end
        end
        1: if (m_press) begin
          m_mode = 2; m_rom = 0; m_ram = 0; m_err = 0; m_since = -1;
        end
        default: begin
          if (upg_wen_i) begin
            if (upg_adr_i[14]) m_ram = (m_ram < SAT) ? m_ram + 1 : SAT;
            else               m_rom = (m_rom < SAT) ? m_rom + 1 : SAT;
            m_since = 0;
          end else if (m_since >= 0) begin
            m_since++;
          end
          if (upg_done_i) begin
            m_mode = 0; m_rel = 0;
          end else if (TO_EN && m_since == TO) begin
            m_mode = 0; m_rel = 0; m_err = 1;
          end
        end
      endcase
    end
  end

  always @(negedge clock) begin
    check("mode", int'(mode_o), m_mode);
    check("upg_rst", int'(upg_rst_o), (m_mode == 2) ? 0 : 1);
    check("cpu_rst", int'(cpu_rst_o), (m_mode == 1) ? 0 : 1);
    check("rom_wen", int'(rom_wen_o), int'(m_mode == 2 && upg_wen_i && !upg_adr_i[14]));
    check("ram_wen", int'(ram_wen_o), int'(m_mode == 2 && upg_wen_i && upg_adr_i[14]));
    check("rom_words", int'(rom_words_o), m_rom);
    check("ram_words", int'(ram_words_o), m_ram);
    check("prog_err", int'(prog_err_o), m_err);
  end

  task automatic pulse_btn(input int n);
    @(posedge clock); #1 start_pg = 1'b1;
    repeat (n) @(posedge clock);
    #1 start_pg = 1'b0;
  endtask

  task automatic wait_mode(input int m, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (int'(mode_o) == m) break;
    end
    check("wait_mode", int'(mode_o), m);
  endtask

  task automatic write_word(input logic [14:0] adr);
    @(posedge clock); #1 upg_wen_i = 1'b1; upg_adr_i = adr;
  endtask

  task automatic done_pulse();
    @(posedge clock); #1 upg_wen_i = 1'b0; upg_done_i = 1'b1;
    @(posedge clock); #1 upg_done_i = 1'b0;
  endtask

  int n, rp, rq;
  logic [14:0] adrs [3];

  initial begin
    adrs[0] = 15'h0004; adrs[1] = 15'h4008; adrs[2] = 15'h0010;
    #2;
    check("rst_mode", int'(mode_o), 0);
    check("rst_cpu_rst", int'(cpu_rst_o), 1);
    check("rst_upg_rst", int'(upg_rst_o), 1);
    check("rst_rom_words", int'(rom_words_o), 0);
    check("rst_err", int'(prog_err_o), 0);
    @(posedge clock); #1 reset = 1'b1;

    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (cpu_rst_o) n++;
      else break;
    end
    check("release_cycles", n, 3);
    check("run_after_release", int'(mode_o), 1);

    pulse_btn(2);
    repeat (10) @(posedge clock);
    #1 check("glitch_no_prog", int'(mode_o), 1);

    pulse_btn(6);
    wait_mode(2, 20);
    check("prog_upg_rst", int'(upg_rst_o), 0);
    repeat (10) @(posedge clock);
    #1 check("single_entry", int'(mode_o), 2);

    rp = 0; rq = 0;
    for (int i = 0; i < 3; i++) begin
      write_word(adrs[i]);
      #1 rp += int'(rom_wen_o); rq += int'(ram_wen_o);
    end
    @(posedge clock); #1 upg_wen_i = 1'b0;
    check("rom_pulses", rp, 2);
    check("ram_pulses", rq, 1);
    check("rom_words_3w", int'(rom_words_o), 2);
    check("ram_words_3w", int'(ram_words_o), 1);

    @(posedge clock); #1 upg_wen_i = 1'b1; upg_adr_i = 15'h4000; upg_done_i = 1'b1;
    @(posedge clock); #1 upg_wen_i = 1'b0; upg_done_i = 1'b0;
    check("done_release", int'(mode_o), 0);
    check("done_ram_words", int'(ram_words_o), 2);
    repeat (3) @(posedge clock);
    #1 check("done_run", int'(mode_o), 1);

    pulse_btn(6);
    wait_mode(2, 20);
    check("entry_clears_rom", int'(rom_words_o), 0);
    write_word(15'h0000);
    @(posedge clock); #1 upg_wen_i = 1'b0;
    repeat (11) @(posedge clock);
    #1 check("timeout_mode", int'(mode_o), TO_EN ? 0 : 2);
    check("timeout_err", int'(prog_err_o), TO_EN ? 1 : 0);
    if (mode_o == 2'd2) done_pulse();
    wait_mode(1, 30);
    pulse_btn(6);
    wait_mode(2, 20);
    check("press_clears_err", int'(prog_err_o), 0);

    for (int i = 0; i < SAT + 7; i++) write_word(15'h0000);
    @(posedge clock); #1 upg_wen_i = 1'b0;
    check("rom_saturate", int'(rom_words_o), SAT);
    check("ram_untouched", int'(ram_words_o), 0);

    done_pulse();
    wait_mode(1, 30);
    pulse_btn(6);
    wait_mode(2, 20);
    for (int i = 0; i < 5; i++) write_word((i % 2 == 1) ? 15'h4001 : 15'h0001);
    #3 reset = 1'b0;
    #1;
    check("midrst_mode", int'(mode_o), 0);
    check("midrst_rom_wen", int'(rom_wen_o), 0);
    check("midrst_ram_wen", int'(ram_wen_o), 0);
    check("midrst_rom_words", int'(rom_words_o), 0);
    check("midrst_ram_words", int'(ram_words_o), 0);
    upg_wen_i = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    wait_mode(1, 20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
